// File: rtl/branch_predictor_gshare_if.sv
// Fetch/commit-side bundle for the gshare predictor. The fetch stage and ROB
// drive queries and training (master); the predictor answers (slave).
interface branch_predictor_gshare_if #(
    parameter int unsigned HIST_LEN = 8
);
    logic                query_valid;
    logic [31:0]         input_pc;
    logic [31:0]         input_inst;
    logic                is_jump_flag;
    logic [31:0]         output_target;
    logic [HIST_LEN-1:0] output_ghr;
    logic                is_update_flag;
    logic                jumped_flag;
    logic [31:0]         rob_pc;
    logic [HIST_LEN-1:0] rob_ghr;
    logic                clear_flag;

    modport master (
        output query_valid, input_pc, input_inst,
        output is_update_flag, jumped_flag, rob_pc, rob_ghr, clear_flag,
        input  is_jump_flag, output_target, output_ghr
    );

    modport slave (
        input  query_valid, input_pc, input_inst,
        input  is_update_flag, jumped_flag, rob_pc, rob_ghr, clear_flag,
        output is_jump_flag, output_target, output_ghr
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// gshare branch predictor: 2^IDX_BITS saturating counters indexed by PC ^ GHR.
// Prediction is combinational; the GHR shifts speculatively on fetched
// conditional branches and is repaired by the ROB on a flush.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor_gshare #(
    parameter int unsigned IDX_BITS  = 8,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned HIST_LEN  = 8,
    parameter int unsigned RAS_DEPTH = 4
) (
    input logic                      clk,
    input logic                      rst,
    input logic                      rdy,
    branch_predictor_gshare_if.slave bp
);
    localparam int unsigned         TblSize  = 2 ** IDX_BITS;
    localparam logic [CNT_BITS-1:0] CntInit  = {1'b0, {(CNT_BITS-1){1'b1}}};
    localparam logic [CNT_BITS-1:0] CntMax   = '1;
    localparam logic [6:0]          OpBranch = 7'b1100011;
    localparam logic [6:0]          OpJal    = 7'b1101111;

    logic [CNT_BITS-1:0] cnt_q [TblSize];
    logic [CNT_BITS-1:0] cnt_cur, cnt_trained;
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic [HIST_LEN:0]   ghr_shift, ghr_repair;
    logic [IDX_BITS-1:0] q_idx, t_idx;
    logic [6:0]          opcode;
    logic [31:0]         imm_b, imm_j;
    logic                is_br, is_jal, pred_br;
    logic                unused_bits;

    assign opcode = bp.input_inst[6:0];
    assign is_br  = (opcode == OpBranch);
    assign is_jal = (opcode == OpJal);
    assign imm_b  = {{20{bp.input_inst[31]}}, bp.input_inst[7], bp.input_inst[30:25],
                     bp.input_inst[11:8], 1'b0};
    assign imm_j  = {{12{bp.input_inst[31]}}, bp.input_inst[19:12], bp.input_inst[20],
                     bp.input_inst[30:21], 1'b0};

    assign q_idx   = bp.input_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign t_idx   = bp.rob_pc[IDX_BITS+1:2] ^ IDX_BITS'(bp.rob_ghr);
    assign pred_br = cnt_q[q_idx][CNT_BITS-1];
    assign cnt_cur = cnt_q[t_idx];

    // The oldest history bit falls off the top of these concatenations.
    assign ghr_shift  = {ghr_q, pred_br};
    assign ghr_repair = {bp.rob_ghr, bp.jumped_flag};

    assign bp.output_ghr = ghr_q;
    assign unused_bits   = ^{ghr_shift[HIST_LEN], ghr_repair[HIST_LEN],
                             bp.rob_pc[31:IDX_BITS+2], bp.rob_pc[1:0]};

`ifdef BP_RAS_EN
    localparam int unsigned PtrW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned OccW   = $clog2(RAS_DEPTH + 1);
    localparam logic [6:0]  OpJalr = 7'b1100111;

    logic [31:0]     ras_q [RAS_DEPTH];
    logic [PtrW-1:0] top_q, top_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic [4:0]      rd, rs1;
    logic            is_call, is_ret, ras_hit, ras_push, ras_pop;

    assign rd       = bp.input_inst[11:7];
    assign rs1      = bp.input_inst[19:15];
    assign is_call  = is_jal && (rd == 5'd1 || rd == 5'd5);
    assign is_ret   = (opcode == OpJalr) && (rd == 5'd0) && (rs1 == 5'd1 || rs1 == 5'd5);
    assign ras_hit  = is_ret && (occ_q != '0);
    assign ras_push = rdy && bp.query_valid && is_call;
    assign ras_pop  = rdy && bp.query_valid && ras_hit;

    // Circular stack: a push when full overwrites the oldest slot, count saturates.
    always_comb begin
        top_d = top_q;
        occ_d = occ_q;
        if (ras_push) begin
            top_d = top_q + PtrW'(1);
            if (occ_q != OccW'(RAS_DEPTH)) occ_d = occ_q + OccW'(1);
        end else if (ras_pop) begin
            top_d = top_q - PtrW'(1);
            occ_d = occ_q - OccW'(1);
        end
    end

    // RAS pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            occ_q <= '0;
        end else begin
            top_q <= top_d;
            occ_q <= occ_d;
        end
    end

    // RAS storage needs no reset; occupancy marks validity.
    always_ff @(posedge clk) begin
        if (!rst && ras_push) ras_q[top_d] <= bp.input_pc + 32'd4;
    end
`endif

    // Combinational prediction for whatever instruction is presented.
    always_comb begin
        bp.is_jump_flag  = 1'b0;
        bp.output_target = bp.input_pc + imm_b;
        if (is_jal) begin
            bp.is_jump_flag  = 1'b1;
            bp.output_target = bp.input_pc + imm_j;
        end else if (is_br) begin
            bp.is_jump_flag = pred_br;
`ifdef BP_RAS_EN
        end else if (ras_hit) begin
            bp.is_jump_flag  = 1'b1;
            bp.output_target = ras_q[top_q];
`endif
        end
    end

    // Saturating move of the committing branch's counter toward its outcome.
    always_comb begin
        cnt_trained = cnt_cur;
        if (bp.jumped_flag) begin
            if (cnt_cur != CntMax) cnt_trained = cnt_cur + CNT_BITS'(1);
        end else if (cnt_cur != '0) begin
            cnt_trained = cnt_cur - CNT_BITS'(1);
        end
    end

    // Flush repair wins over a same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (rdy) begin
            if (bp.clear_flag) begin
                ghr_d = ghr_repair[HIST_LEN-1:0];
            end else if (bp.query_valid && is_br) begin
                ghr_d = ghr_shift[HIST_LEN-1:0];
            end
        end
    end

    // Global history register.
    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end

    // Counter table: reset to weak not-taken, trained at commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TblSize; i++) cnt_q[i] <= CntInit;
        end else if (rdy && bp.is_update_flag) begin
            cnt_q[t_idx] <= cnt_trained;
        end
    end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: directed steps from the feature list, then
// randomized traffic checked against an arithmetic reference model.
module tb_branch_predictor_gshare;
    localparam int unsigned IDX_BITS  = 8;
    localparam int unsigned CNT_BITS  = 2;
    localparam int unsigned HIST_LEN  = 8;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned TBL       = 2 ** IDX_BITS;
    localparam int unsigned CNT_MAX   = 2 ** CNT_BITS - 1;
    localparam int unsigned CNT_INIT  = 2 ** (CNT_BITS - 1) - 1;
    localparam int unsigned CNT_HALF  = 2 ** (CNT_BITS - 1);
    localparam int unsigned GHR_MOD   = 2 ** HIST_LEN;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    branch_predictor_gshare_if #(.HIST_LEN(HIST_LEN)) bp_if ();

    branch_predictor_gshare #(
        .IDX_BITS (IDX_BITS),
        .CNT_BITS (CNT_BITS),
        .HIST_LEN (HIST_LEN),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bp (bp_if.slave)
    );

    always #5 clk = ~clk;

    typedef enum int {KBr, KJal, KRet, KOther} kind_e;

    kind_e       cur_kind;
    int          cur_imm;
    bit          cur_call;
    int unsigned m_cnt [TBL];
    int unsigned m_ghr;
    logic [31:0] m_ras [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc, input int unsigned g);
        return (32'(pc >> 2) % TBL) ^ g;
    endfunction

    function automatic logic [31:0] enc_b(input int imm);
        logic [12:0] v;
        v = imm[12:0];
        return {v[12], v[10:5], 5'd0, 5'd0, 3'b000, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
        logic [20:0] v;
        v = imm[20:0];
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic set_br(input logic [31:0] pc, input int imm, input logic qv);
        bp_if.input_pc = pc; bp_if.input_inst = enc_b(imm); bp_if.query_valid = qv;
        cur_kind = KBr; cur_imm = imm; cur_call = 0;
    endtask

    task automatic set_jal(input logic [31:0] pc, input int imm, input logic [4:0] rd,
                           input logic qv);
        bp_if.input_pc = pc; bp_if.input_inst = enc_j(imm, rd); bp_if.query_valid = qv;
        cur_kind = KJal; cur_imm = imm; cur_call = (rd == 5'd1 || rd == 5'd5);
    endtask

    task automatic set_ret(input logic [31:0] pc, input logic [4:0] rs1, input logic qv);
        bp_if.input_pc = pc; bp_if.input_inst = enc_jalr(5'd0, rs1); bp_if.query_valid = qv;
        cur_kind = KRet; cur_imm = 0; cur_call = 0;
    endtask

    task automatic set_other(input logic [31:0] pc, input logic [31:0] inst, input logic qv);
        bp_if.input_pc = pc; bp_if.input_inst = inst; bp_if.query_valid = qv;
        cur_kind = KOther; cur_imm = 0; cur_call = 0;
    endtask

    task automatic set_rob(input logic upd, input logic [31:0] pc, input logic [7:0] ghr,
                           input logic jumped, input logic clr);
        bp_if.is_update_flag = upd; bp_if.rob_pc = pc; bp_if.rob_ghr = ghr;
        bp_if.jumped_flag = jumped; bp_if.clear_flag = clr;
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = CNT_INIT;
        m_ghr = 0;
        m_ras.delete();
    endtask

    // Apply the state change implied by the inputs sampled at this posedge.
    task automatic model_update(input int unsigned c);
        int unsigned ti;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        if (bp_if.is_update_flag) begin
            ti = idx_of(bp_if.rob_pc, int'(bp_if.rob_ghr));
            if (bp_if.jumped_flag) begin
                if (m_cnt[ti] < CNT_MAX) m_cnt[ti]++;
            end else if (m_cnt[ti] > 0) begin
                m_cnt[ti]--;
            end
        end
        if (bp_if.clear_flag)
            m_ghr = (int'(bp_if.rob_ghr) * 2 + int'(bp_if.jumped_flag)) % GHR_MOD;
        else if (bp_if.query_valid && cur_kind == KBr)
            m_ghr = (m_ghr * 2 + ((c >= CNT_HALF) ? 1 : 0)) % GHR_MOD;
`ifdef BP_RAS_EN
        if (bp_if.query_valid && cur_kind == KJal && cur_call) begin
            m_ras.push_back(bp_if.input_pc + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (bp_if.query_valid && cur_kind == KRet && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
`endif
    endtask

    // Check the combinational outputs against the model, then clock once.
    task automatic tick();
        logic        exp_jump;
        logic [31:0] exp_tgt;
        bit          chk_tgt;
        int unsigned c;
        #1;
        c = m_cnt[idx_of(bp_if.input_pc, m_ghr)];
        exp_jump = 1'b0; exp_tgt = '0; chk_tgt = 0;
        case (cur_kind)
            KBr: begin
                exp_jump = (c >= CNT_HALF);
                exp_tgt  = bp_if.input_pc + 32'(cur_imm);
                chk_tgt  = 1;
            end
            KJal: begin
                exp_jump = 1'b1;
                exp_tgt  = bp_if.input_pc + 32'(cur_imm);
                chk_tgt  = 1;
            end
            KRet: begin
`ifdef BP_RAS_EN
                if (m_ras.size() > 0) begin
                    exp_jump = 1'b1;
                    exp_tgt  = m_ras[$];
                    chk_tgt  = 1;
                end
`endif
            end
            default: ;
        endcase
        check("jump", 32'(bp_if.is_jump_flag), 32'(exp_jump));
        if (chk_tgt) check("target", bp_if.output_target, exp_tgt);
        check("ghr", 32'(bp_if.output_ghr), m_ghr);
        @(posedge clk);
        model_update(c);
        @(negedge clk);
    endtask

    initial begin
        int          k;
        logic [31:0] pc;
        logic [4:0]  rd;

        rst = 1'b1;
        rdy = 1'b1;
        set_other(32'h0, 32'h0, 1'b0);
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset state seen through a beq at 0x100, imm +16.
        set_br(32'h100, 16, 1'b0);
        #1;
        check("rst_jump", 32'(bp_if.is_jump_flag), 32'h0);
        check("rst_target", bp_if.output_target, 32'h110);
        check("rst_ghr", 32'(bp_if.output_ghr), 32'h0);
        tick();

        // Two taken trainings flip the prediction.
        set_other(32'h0, 32'h0, 1'b0);
        set_rob(1'b1, 32'h100, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        set_br(32'h100, 16, 1'b0);
        #1;
        check("train2_jump", 32'(bp_if.is_jump_flag), 32'h1);
        tick();

        // Saturate, then one not-taken: still taken.
        set_other(32'h0, 32'h0, 1'b0);
        set_rob(1'b1, 32'h100, 8'h00, 1'b1, 1'b0);
        tick();
        set_rob(1'b1, 32'h100, 8'h00, 1'b0, 1'b0);
        tick();
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        set_br(32'h100, 16, 1'b0);
        #1;
        check("sat_jump", 32'(bp_if.is_jump_flag), 32'h1);
        tick();

        // Prime the entry that the third branch will hit with GHR=2.
        set_other(32'h0, 32'h0, 1'b0);
        set_rob(1'b1, 32'h400, 8'h02, 1'b1, 1'b0);
        tick();
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);

        // Three fetched branches predicted 1,0,1.
        set_br(32'h100, 16, 1'b1);
        tick();
        set_br(32'h300, -32, 1'b1);
        tick();
        set_br(32'h400, 8, 1'b1);
        tick();
        set_br(32'h500, 4, 1'b0);
        set_rob(1'b0, 32'h0, 8'h01, 1'b0, 1'b1);
        #1;
        check("hist_ghr", 32'(bp_if.output_ghr), 32'h05);
        tick();
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        #1;
        check("repair_ghr", 32'(bp_if.output_ghr), 32'h02);
        tick();

        // Query shift and repair in the same cycle: repair wins.
        set_br(32'h100, 16, 1'b1);
        set_rob(1'b0, 32'h0, 8'h30, 1'b1, 1'b1);
        tick();
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        set_other(32'h0, 32'h0, 1'b0);
        #1;
        check("collide_ghr", 32'(bp_if.output_ghr), 32'h61);
        tick();

        // rdy low freezes everything.
        rdy = 1'b0;
        set_br(32'h100, 16, 1'b1);
        set_rob(1'b1, 32'h100, 8'h61, 1'b0, 1'b1);
        tick();
        rdy = 1'b1;
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        set_other(32'h0, 32'h0, 1'b0);
        #1;
        check("frozen_ghr", 32'(bp_if.output_ghr), 32'h61);
        tick();

        // JAL at 0x200, imm -8.
        set_jal(32'h200, -8, 5'd0, 1'b1);
        #1;
        check("jal_jump", 32'(bp_if.is_jump_flag), 32'h1);
        check("jal_target", bp_if.output_target, 32'h1F8);
        tick();
        set_other(32'h0, 32'h0, 1'b0);
        #1;
        check("jal_ghr", 32'(bp_if.output_ghr), 32'h61);
        tick();

        // Calls and returns.
        for (int i = 1; i <= 5; i++) begin
            set_jal(32'(i * 16), 256, 5'd1, 1'b1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_ret(32'h600, 5'd1, 1'b1);
            #1;
`ifdef BP_RAS_EN
            check("ret_jump", 32'(bp_if.is_jump_flag), (i < 4) ? 32'h1 : 32'h0);
            if (i < 4) check("ret_target", bp_if.output_target, 32'(32'h54 - i * 16));
`else
            check("ret_jump", 32'(bp_if.is_jump_flag), 32'h0);
`endif
            tick();
        end

        // Reset mid-stream discards a pending training.
        rst = 1'b1;
        set_other(32'h0, 32'h0, 1'b0);
        set_rob(1'b1, 32'h800, 8'h00, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        set_rob(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        set_br(32'h100, 16, 1'b0);
        #1;
        check("rst2_jump", 32'(bp_if.is_jump_flag), 32'h0);
        check("rst2_ghr", 32'(bp_if.output_ghr), 32'h0);
        tick();
        set_br(32'h800, 16, 1'b0);
        #1;
        check("rst2_discard", 32'(bp_if.is_jump_flag), 32'h0);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            rdy = ($urandom_range(0, 9) != 0);
            pc  = 32'($urandom_range(0, 255)) << 2;
            k   = $urandom_range(0, 3);
            case (k)
                0: set_br(pc, ($urandom_range(0, 4095) - 2048) * 2, ($urandom_range(0, 3) != 0));
                1: begin
                    case ($urandom_range(0, 3))
                        0: rd = 5'd0;
                        1: rd = 5'd1;
                        2: rd = 5'd5;
                        default: rd = 5'd2;
                    endcase
                    set_jal(pc, ($urandom_range(0, 1048575) - 524288) * 2, rd,
                            ($urandom_range(0, 3) != 0));
                end
                2: set_ret(pc, ($urandom_range(0, 1) != 0) ? 5'd5 : 5'd1,
                           ($urandom_range(0, 3) != 0));
                default: begin
                    case ($urandom_range(0, 2))
                        0: set_other(pc, enc_jalr(5'd1, 5'd1), 1'b1);
                        1: set_other(pc, enc_jalr(5'd0, 5'd2), 1'b1);
                        default: set_other(pc, $urandom() & 32'hFFFF_FF93 | 32'h13, 1'b1);
                    endcase
                end
            endcase
            set_rob(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised gshare predictor: a 2^IDX_BITS table of CNT_BITS-wide saturating counters, indexed by PC XOR a speculative global history register (GHR). Sits beside the IF stage, which queries it combinationally per fetched instruction. Trained by the ROB at commit, which also repairs the GHR on a flush. Optional return-address stack (RAS) predicts `jalr` returns.

## Interface
Parameters:
- IDX_BITS, 8, table index width; the table has 2^IDX_BITS entries.
- CNT_BITS, 2, counter width, ≥ 2.
- HIST_LEN, 8, GHR length, 1 ≤ HIST_LEN ≤ IDX_BITS.
- RAS_DEPTH, 4, RAS entries, power of two (RAS_EN only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state is frozen.
- query_valid  in  1  IF presents a real instruction this cycle.
- input_pc  in  32  PC of the queried instruction.
- input_inst  in  32  the queried instruction.
- is_jump_flag  out  1  predict taken.
- output_target  out  32  predicted target, valid when is_jump_flag=1.
- output_ghr  out  HIST_LEN  GHR snapshot before this query; IF carries it to the ROB.
- is_update_flag  in  1  ROB commits a conditional branch.
- jumped_flag  in  1  actual outcome: 1=taken.
- rob_pc  in  32  PC of the committing branch.
- rob_ghr  in  HIST_LEN  output_ghr captured when that branch was fetched.
- clear_flag  in  1  ROB flush on mispredict of the committing branch.

## Operation
- Decode: conditional branch = opcode 1100011; JAL = 1101111; JALR = 1100111. B and J immediates are sign-extended, bit 0 = 0.
- Index: idx = input_pc[IDX_BITS+1:2] XOR {zeros, ghr}. The training index uses rob_pc and rob_ghr in the same way.
- Counter: MSB=1 means taken. Reset value = 2^(CNT_BITS-1)-1 (weak not-taken).
  - Training taken increments the counter, saturating at all-ones.
  - Training not-taken decrements it, saturating at 0.
- Prediction, combinational, output for any instruction regardless of query_valid:
  - JAL: taken; target = input_pc + J-imm.
  - Conditional branch: taken = counter MSB; target = input_pc + B-imm.
  - Otherwise: not taken; target = input_pc + B-imm, don't-care.
- GHR speculative update: when rdy & query_valid & conditional branch & !clear_flag, ghr <= {ghr[HIST_LEN-2:0], predicted bit}. JAL and JALR do not shift the GHR.
- GHR repair: when rdy & clear_flag, ghr <= {rob_ghr[HIST_LEN-2:0], jumped_flag}. Repair overrides any same-cycle query shift.
- Training: when rdy & is_update_flag, the counter at the training index saturates toward jumped_flag. Training and clear_flag may occur in the same cycle and both take effect.
- Reset: all counters at weak not-taken, GHR=0, RAS empty. Outputs after reset, given opcode 0, are is_jump_flag=0 and output_ghr=0.

## Timing
- Prediction latency is 0 cycles (combinational from input_pc, input_inst and state). State changes become visible the cycle after the posedge.
- A query and a training of the same entry in one cycle: the query sees the pre-update counter.
- rdy=0: no GHR shift, no training, no RAS change. Outputs still track inputs combinationally.
- Reset asserted mid-stream: the next cycle is reset state, and pending training is discarded.
- HIST_LEN=1 is legal. The shift degenerates to ghr <= new bit.

## Configuration
- BP_RAS_EN defined:
  - Adds a circular RAS of RAS_DEPTH×32 with top pointer and occupancy count.
  - Push: rdy & query_valid & JAL with rd∈{x1,x5}; pushes input_pc+4.
    - When full, the push overwrites the oldest entry; the count stays at RAS_DEPTH.
  - Return: JALR with rd=x0 and rs1∈{x1,x5}.
    - If count>0: is_jump_flag=1, output_target = top entry; when query_valid & rdy, pop.
    - If empty: not taken.
  - clear_flag does not alter the RAS.
  - Other JALR forms predict not taken.
- Undefined: no RAS storage; every JALR predicts not taken.

## Test plan
- Reset, then query `beq` at pc 0x100 (imm +16) → is_jump_flag=0, output_target=0x110, output_ghr=0.
- Train pc 0x100 with rob_ghr=0 as taken twice, then query again with GHR=0 → is_jump_flag=1. Train it a third time → the counter saturates at 3; then one not-taken training → prediction is still taken.
- Query 3 conditional branches predicted {1,0,1} with query_valid=1, HIST_LEN=8 → output_ghr on the 4th query = 8'b00000101. Then clear_flag with rob_ghr=8'h01 and jumped_flag=0 → next output_ghr = 8'h02.
- Same cycle: query of a conditional branch and clear_flag → GHR takes the repair value only. Same cycle with rdy=0 → GHR unchanged.
- JAL at 0x200 with imm -8 → is_jump_flag=1, output_target=0x1F8, GHR unchanged.
- BP_RAS_EN, RAS_DEPTH=4:
  - Five JAL x1 calls at pcs 0x10, 0x20, 0x30, 0x40, 0x50, then five `ret` queries → targets 0x54, 0x44, 0x34, 0x24. The fifth `ret` is not taken (empty).
  - Without BP_RAS_EN, every `ret` is not taken.
